adc_scan_sequencer: RTL and testbench

ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

---
 rtl/adc_scan_sequencer_if.sv | 27 ++
 rtl/adc_scan_sequencer.sv | 177 +++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_scan_sequencer_if.sv
// Avalon-ST command/response bundle between adc_scan_sequencer (master) and the ADC (slave).
interface adc_scan_sequencer_if;
  logic        command_valid;
  logic        command_ready;
  logic [4:0]  command_channel;
  logic        command_startofpacket;
  logic        command_endofpacket;
  logic        response_valid;
  logic [4:0]  response_channel;
  logic [11:0] response_data;
  logic        response_startofpacket;
  logic        response_endofpacket;

  modport master (
    output command_valid, command_channel, command_startofpacket, command_endofpacket,
    input  command_ready,
    input  response_valid, response_channel, response_data,
    input  response_startofpacket, response_endofpacket
  );

  modport slave (
    input  command_valid, command_channel, command_startofpacket, command_endofpacket,
    output command_ready,
    output response_valid, response_channel, response_data,
    output response_startofpacket, response_endofpacket
  );
endinterface

// File: rtl/adc_scan_sequencer.sv
// Round-robin ADC channel scanner: one outstanding command, per-channel sample store, sticky error flags.
// Build macro ADC_SCAN_AVG_EN: publish 4-scan averages instead of raw samples.
module adc_scan_sequencer #(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned CH_BASE     = 1,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic                 enable,
  input  logic                 err_clr,
  adc_scan_sequencer_if.master adc,
  input  logic [3:0]           rd_index,
  output logic [11:0]          rd_data,
  output logic                 scan_done,
  output logic                 busy,
  output logic                 err_mismatch,
  output logic                 err_timeout
);
  localparam int unsigned TW      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [3:0]  LAST    = 4'(NUM_CH - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, NEXT} state_t;

  state_t        r_state;
  logic [3:0]    r_idx;
  logic [TW-1:0] r_timer;
  logic          r_cmd_valid;
  logic [4:0]    r_cmd_ch;
  logic          r_cmd_sop;
  logic          r_cmd_eop;
  logic          r_scan_done;
  logic          r_err_mm;
  logic          r_err_to;
  logic [11:0]   r_sample [16];
`ifdef ADC_SCAN_AVG_EN
  logic [13:0]   r_acc [16];
  logic [1:0]    r_pass;
`endif

  logic       w_last;
  logic [3:0] w_cmd_idx;
  logic [4:0] w_cmd_ch;
  logic [4:0] w_exp_ch;
  logic       w_rsp_hit;
  logic       w_set_mm;
  logic       w_set_to;
  logic       w_load;
  logic       w_unused_sop_eop;

  assign w_unused_sop_eop = adc.response_startofpacket ^ adc.response_endofpacket;

  // w_cmd_idx is the scan index of the command about to be loaded (0 on scan start/wrap).
  always_comb begin
    w_last    = (r_idx == LAST);
    w_cmd_idx = (r_state == NEXT && !w_last) ? r_idx + 4'd1 : '0;
    w_cmd_ch  = 5'(CH_BASE + {28'd0, w_cmd_idx});
    w_exp_ch  = 5'(CH_BASE + {28'd0, r_idx});
    w_rsp_hit = (r_state == WAIT_RSP) && adc.response_valid && (adc.response_channel == w_exp_ch);
    w_set_mm  = (r_state == WAIT_RSP) && adc.response_valid && (adc.response_channel != w_exp_ch);
    w_set_to  = (r_state == WAIT_RSP) && !adc.response_valid && (r_timer == TO_LAST);
    w_load    = ((r_state == IDLE) && enable) || ((r_state == NEXT) && (!w_last || enable));
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_timer     <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_ch    <= '0;
      r_cmd_sop   <= 1'b0;
      r_cmd_eop   <= 1'b0;
      r_scan_done <= 1'b0;
      r_err_mm    <= 1'b0;
      r_err_to    <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
        r_sample[i] <= '0;
      end
`ifdef ADC_SCAN_AVG_EN
      for (int unsigned i = 0; i < 16; i++) begin
        r_acc[i] <= '0;
      end
      r_pass <= '0;
`endif
    end else begin
      r_scan_done <= 1'b0;

      case (r_state)
        IDLE: begin
          if (enable) begin
            r_idx   <= w_cmd_idx;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (adc.command_ready) begin
            r_state     <= WAIT_RSP;
            r_cmd_valid <= 1'b0;
            r_cmd_sop   <= 1'b0;
            r_cmd_eop   <= 1'b0;
            r_timer     <= '0;
          end
        end
        WAIT_RSP: begin
          if (w_rsp_hit) begin
`ifdef ADC_SCAN_AVG_EN
            r_acc[r_idx] <= r_acc[r_idx] + 14'(adc.response_data);
`else
            r_sample[r_idx] <= adc.response_data;
`endif
          end
          if (adc.response_valid || w_set_to) begin
            r_state <= NEXT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        NEXT: begin
          r_idx   <= w_cmd_idx;
          r_state <= w_load ? ISSUE : IDLE;
          if (w_last) begin
`ifdef ADC_SCAN_AVG_EN
            r_pass <= r_pass + 2'd1;
            if (r_pass == 2'd3) begin
              for (int unsigned i = 0; i < 16; i++) begin
                r_sample[i] <= r_acc[i][13:2];
                r_acc[i]    <= '0;
              end
              r_scan_done <= 1'b1;
            end
`else
            r_scan_done <= 1'b1;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_load) begin
        r_cmd_valid <= 1'b1;
        r_cmd_ch    <= w_cmd_ch;
        r_cmd_sop   <= (w_cmd_idx == 4'd0);
        r_cmd_eop   <= (w_cmd_idx == LAST);
      end

      // Setting a flag takes priority over a coincident clear.
      if (w_set_mm) begin
        r_err_mm <= 1'b1;
      end else if (err_clr) begin
        r_err_mm <= 1'b0;
      end
      if (w_set_to) begin
        r_err_to <= 1'b1;
      end else if (err_clr) begin
        r_err_to <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if ({28'd0, rd_index} < NUM_CH) begin
      rd_data = r_sample[rd_index];
    end
  end

  assign adc.command_valid         = r_cmd_valid;
  assign adc.command_channel       = r_cmd_ch;
  assign adc.command_startofpacket = r_cmd_sop;
  assign adc.command_endofpacket   = r_cmd_eop;
  assign scan_done                 = r_scan_done;
  assign busy                      = (r_state != IDLE);
  assign err_mismatch              = r_err_mm;
  assign err_timeout               = r_err_to;
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Scoreboard bench for adc_scan_sequencer: NUM_CH=4, CH_BASE=1, TIMEOUT_CYC=15, ADC model answering 3 cycles after each command.
module tb_adc_scan_sequencer;
`ifdef ADC_SCAN_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        enable;
  logic        clr_stim;
  logic        clr_rsp;
  logic        err_clr;
  logic [3:0]  rd_index;
  logic [11:0] rd_data;
  logic        scan_done;
  logic        busy;
  logic        err_mismatch;
  logic        err_timeout;

  adc_scan_sequencer_if ifc ();

  assign err_clr = clr_stim | clr_rsp;

  adc_scan_sequencer #(
    .NUM_CH      (4),
    .CH_BASE     (1),
    .TIMEOUT_CYC (15)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset  (reset_reset),
    .enable       (enable),
    .err_clr      (err_clr),
    .adc          (ifc.master),
    .rd_index     (rd_index),
    .rd_data      (rd_data),
    .scan_done    (scan_done),
    .busy         (busy),
    .err_mismatch (err_mismatch),
    .err_timeout  (err_timeout)
  );

  always #5 clk_clk = ~clk_clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [6:0] q_cmd [$];
  int         q_done [$];

  // ADC plan per channel: kind 0 = no answer, 1 = answer with plan_ch/plan_data.
  logic        plan_kind [32];
  logic [4:0]  plan_ch   [32];
  logic [11:0] plan_data [32];
  logic        plan_clr  [32];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Command / scan_done monitor: pops expectations when the DUT presents them.
  always @(negedge clk_clk) begin
    if (!reset_reset) begin
      if (ifc.command_valid) begin
        if (q_cmd.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_cmd: got ch %0d, expected no command", ifc.command_channel);
        end else begin
          check("cmd{ch,sop,eop}",
                32'({ifc.command_channel, ifc.command_startofpacket, ifc.command_endofpacket}),
                32'(q_cmd[0]));
          if (ifc.command_ready) void'(q_cmd.pop_front());
        end
      end
      if (scan_done) begin
        vectors++;
        if (q_done.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_scan_done: got pulse, expected none");
        end else begin
          void'(q_done.pop_front());
        end
      end
    end
  end

  // ADC responder: one response, RSP_DLY=3 cycles after each accepted command.
  initial begin
    logic [4:0] c;
    ifc.response_valid         = 1'b0;
    ifc.response_channel       = '0;
    ifc.response_data          = '0;
    ifc.response_startofpacket = 1'b0;
    ifc.response_endofpacket   = 1'b0;
    clr_rsp                    = 1'b0;
    forever begin
      @(negedge clk_clk);
      if (ifc.command_valid && ifc.command_ready && !reset_reset) begin
        c = ifc.command_channel;
        repeat (3) @(posedge clk_clk);
        #1;
        if (plan_kind[c]) begin
          ifc.response_valid         = 1'b1;
          ifc.response_channel       = plan_ch[c];
          ifc.response_data          = plan_data[c];
          ifc.response_startofpacket = 1'b1;
          ifc.response_endofpacket   = 1'b1;
          clr_rsp                    = plan_clr[c];
          @(posedge clk_clk);
          #1;
          ifc.response_valid         = 1'b0;
          ifc.response_startofpacket = 1'b0;
          ifc.response_endofpacket   = 1'b0;
          clr_rsp                    = 1'b0;
        end
      end
    end
  end

  task automatic set_plan_normal(input int unsigned base);
    for (int unsigned c = 0; c < 32; c++) begin
      plan_kind[c] = (c >= 1 && c <= 4);
      plan_ch[c]   = 5'(c);
      plan_data[c] = 12'(base + c);
      plan_clr[c]  = 1'b0;
    end
  endtask

  task automatic push_scan(input bit with_done);
    for (int unsigned c = 1; c <= 4; c++) begin
      q_cmd.push_back({5'(c), (c == 1), (c == 4)});
    end
    if (with_done) q_done.push_back(1);
  endtask

  task automatic do_reset();
    @(posedge clk_clk); #1 reset_reset = 1'b1;
    repeat (2) @(posedge clk_clk);
    #1 reset_reset = 1'b0;
  endtask

  task automatic start_scan();
    @(posedge clk_clk); #1 enable = 1'b1;
    @(posedge clk_clk); #1 enable = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin
      @(negedge clk_clk);
      n++;
    end while (busy && n < 400);
    vectors++;
    if (busy) begin
      miscompares++;
      $display("FAIL %s: busy still 1 after %0d cycles, expected 0", nm, n);
    end
  endtask

  task automatic wait_xfer(input logic [4:0] ch, input string nm);
    int n = 0;
    do begin
      @(negedge clk_clk);
      n++;
    end while (!(ifc.command_valid && ifc.command_ready && ifc.command_channel == ch) && n < 400);
    vectors++;
    if (!(ifc.command_valid && ifc.command_ready && ifc.command_channel == ch)) begin
      miscompares++;
      $display("FAIL %s: no transfer of ch %0d within %0d cycles", nm, ch, n);
    end
  endtask

  task automatic check_rd(input int unsigned idx, input logic [11:0] exp, input string nm);
    rd_index = 4'(idx);
    #1;
    check(nm, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_reset       = 1'b1;
    enable            = 1'b0;
    clr_stim          = 1'b0;
    rd_index          = '0;
    ifc.command_ready = 1'b1;
    set_plan_normal(32'h100);
    repeat (3) @(posedge clk_clk);
    #1 reset_reset = 1'b0;

    // Reset state
    @(negedge clk_clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_cmd", 32'({ifc.command_valid, ifc.command_channel, ifc.command_startofpacket,
                          ifc.command_endofpacket}), 32'h0);
    check("rst_flags", 32'({scan_done, err_mismatch, err_timeout}), 32'h0);
    for (int unsigned i = 0; i < 4; i++) check_rd(i, 12'h000, "rst_rd");

    // Basic single scan, data 0x100+ch
    push_scan(!AVG);
    start_scan();
    wait_idle("scan1_idle");
    check_rd(0, AVG ? 12'h000 : 12'h101, "scan1_rd0");
    check_rd(1, AVG ? 12'h000 : 12'h102, "scan1_rd1");
    check_rd(2, AVG ? 12'h000 : 12'h103, "scan1_rd2");
    check_rd(3, AVG ? 12'h000 : 12'h104, "scan1_rd3");
    check_rd(4, 12'h000, "rd_idx4_oob");
    check_rd(15, 12'h000, "rd_idx15_oob");
    check("scan1_flags", 32'({err_mismatch, err_timeout}), 32'h0);

    // Backpressure: ready low for 10 cycles on the first command
    do_reset();
    set_plan_normal(32'h300);
    ifc.command_ready = 1'b0;
    push_scan(!AVG);
    start_scan();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_clk);
      check("stall_valid", 32'(ifc.command_valid), 32'h1);
    end
    @(posedge clk_clk); #1 ifc.command_ready = 1'b1;
    wait_idle("stall_idle");
    check_rd(0, AVG ? 12'h000 : 12'h301, "stall_rd0");

    // Mismatch: ch5 answers while waiting for ch2, with coincident err_clr
    do_reset();
    set_plan_normal(32'h200);
    push_scan(!AVG);
    start_scan();
    wait_idle("mm_scanA_idle");
    set_plan_normal(32'h300);
    plan_ch[2]   = 5'd5;
    plan_data[2] = 12'hABC;
    plan_clr[2]  = 1'b1;
    push_scan(!AVG);
    start_scan();
    wait_idle("mm_scanB_idle");
    check("mm_flag_set_wins", 32'(err_mismatch), 32'h1);
    check("mm_no_timeout", 32'(err_timeout), 32'h0);
    check_rd(0, AVG ? 12'h000 : 12'h301, "mm_rd0");
    check_rd(1, AVG ? 12'h000 : 12'h202, "mm_rd1_kept");
    check_rd(2, AVG ? 12'h000 : 12'h303, "mm_rd2");
    @(posedge clk_clk); #1 clr_stim = 1'b1;
    @(posedge clk_clk); #1 clr_stim = 1'b0;
    @(negedge clk_clk);
    check("mm_cleared", 32'(err_mismatch), 32'h0);

    // Timeout on ch3: flag rises on the 15th wait cycle, scan goes on with ch4
    do_reset();
    set_plan_normal(32'h400);
    plan_kind[3] = 1'b0;
    push_scan(!AVG);
    start_scan();
    wait_xfer(5'd3, "to_ch3_xfer");
    repeat (15) @(negedge clk_clk);
    check("to_before_15", 32'(err_timeout), 32'h0);
    @(negedge clk_clk);
    check("to_at_15", 32'(err_timeout), 32'h1);
    wait_idle("to_idle");
    check_rd(2, 12'h000, "to_rd2_kept");
    check_rd(3, AVG ? 12'h000 : 12'h404, "to_rd3");
    check("to_no_mm", 32'(err_mismatch), 32'h0);

    // Continuous scans; enable dropped during the second scan's ch2 wait
    do_reset();
    set_plan_normal(32'h500);
    push_scan(!AVG);
    push_scan(!AVG);
    @(posedge clk_clk); #1 enable = 1'b1;
    wait_xfer(5'd2, "en_first_ch2");
    wait_xfer(5'd2, "en_second_ch2");
    @(posedge clk_clk); #1 enable = 1'b0;
    wait_idle("en_idle");
    repeat (20) @(negedge clk_clk);
    check("en_quiet", 32'({busy, ifc.command_valid}), 32'h0);

    // Reset mid-transaction; late wrong-channel response must be ignored
    do_reset();
    set_plan_normal(32'h600);
    plan_ch[1] = 5'd7;
    q_cmd.push_back({5'd1, 1'b1, 1'b0});
    start_scan();
    wait_xfer(5'd1, "rst_mid_xfer");
    @(posedge clk_clk); #1 reset_reset = 1'b1;
    @(posedge clk_clk); #1 reset_reset = 1'b0;
    repeat (8) @(negedge clk_clk);
    check("rst_mid_state", 32'({busy, err_mismatch, err_timeout}), 32'h0);
    check_rd(0, 12'h000, "rst_mid_rd0");

`ifdef ADC_SCAN_AVG_EN
    // Averaging over 4 scans: ch1 100,200,300,401 -> 250; ch2 8 -> 8; ch3 timed out -> 0; ch4 1..4 -> 2
    begin
      int d1 [4] = '{100, 200, 300, 401};
      do_reset();
      for (int s = 0; s < 4; s++) begin
        set_plan_normal(32'h0);
        plan_data[1] = 12'(d1[s]);
        plan_data[2] = 12'd8;
        plan_kind[3] = 1'b0;
        plan_data[4] = 12'(s + 1);
        push_scan(s == 3);
        start_scan();
        wait_idle("avg_idle");
        if (s == 2) check_rd(0, 12'h000, "avg_unpublished");
      end
      check_rd(0, 12'd250, "avg_rd0");
      check_rd(1, 12'd8, "avg_rd1");
      check_rd(2, 12'd0, "avg_rd2_timeout");
      check_rd(3, 12'd2, "avg_rd3");
    end
`endif

    repeat (5) @(negedge clk_clk);
    check("leftover_cmds", 32'(q_cmd.size()), 32'h0);
    check("leftover_scan_done", 32'(q_done.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
